ibuffer_fifo: RTL and testbench

- Per-warp instruction buffer FIFO that sits directly downstream of the slowdown stage.
- Accepts one decoded control word per cycle over a valid/ready handshake and holds up to DEPTH words in order.
- Presents the oldest word to the warp-scheduler/issue stage over a second valid/ready handshake.
- Supports a pipeline flush that discards all buffered words in one cycle. One instance exists per warp.

---
 rtl/ibuffer_fifo.sv | 84 ++++++++
 tb/tb_ibuffer_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer_fifo.sv
// ibuffer_fifo: per-warp in-order instruction buffer between the slowdown stage and issue.
// Define IBUFFER_FIFO_BYPASS_EN to let a word pass straight through an empty FIFO in the same cycle.
module ibuffer_fifo #(
    parameter int unsigned BUFFER_WIDTH = 155,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [BUFFER_WIDTH-1:0] in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [BUFFER_WIDTH-1:0] out_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [BUFFER_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    empty, full;
    logic                    push, pop, wr_en, bypass;

    // The MSB of each pointer is a wrap bit that separates full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = empty;
    assign full_o  = full;

    assign in_ready_o = !full && !flush_i;
    assign push       = in_valid_i && in_ready_o;

`ifdef IBUFFER_FIFO_BYPASS_EN
    assign bypass      = empty && in_valid_i && !flush_i;
    assign out_valid_o = (!empty || in_valid_i) && !flush_i;
    assign out_data_o  = bypass ? in_data_i : mem_q[rd_ptr_q[AW-1:0]];
`else
    assign bypass      = 1'b0;
    assign out_valid_o = !empty && !flush_i;
    assign out_data_o  = mem_q[rd_ptr_q[AW-1:0]];
`endif

    // A bypassed word that is consumed immediately never touches storage or the pointers.
    assign pop   = out_valid_o && out_ready_i && !bypass;
    assign wr_en = push && !(bypass && out_ready_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_ibuffer_fifo.sv
// tb_ibuffer_fifo: directed and random checks of ibuffer_fifo against a queue reference.
// Expectations follow IBUFFER_FIFO_BYPASS_EN when the bench is built with it defined.
module tb_ibuffer_fifo;

    localparam int BW    = 155;
    localparam int DEPTH = 4;
`ifdef IBUFFER_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [BW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [BW-1:0] out_data_o;
    logic [2:0]    count_o;
    logic          empty_o;
    logic          full_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] q[$];

    ibuffer_fifo #(
        .BUFFER_WIDTH(BW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle's inputs and compare every output with the reference queue.
    task automatic drive(input logic iv, input logic [BW-1:0] d, input logic ordy, input logic fl);
        int            cnt;
        logic          exp_ov;
        logic [BW-1:0] exp_od;
        in_valid_i  = iv;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        #1;
        cnt    = q.size();
        exp_ov = !fl && (cnt > 0 || (BYP && iv));
        exp_od = (cnt > 0) ? q[0] : d;
        check("in_ready", 160'(in_ready_o), 160'(!fl && cnt < DEPTH));
        check("out_valid", 160'(out_valid_o), 160'(exp_ov));
        if (exp_ov) check("out_data", 160'(out_data_o), 160'(exp_od));
        check("count", 160'(count_o), 160'(cnt));
        check("empty", 160'(empty_o), 160'(cnt == 0));
        check("full", 160'(full_o), 160'(cnt == DEPTH));
    endtask

    task automatic commit();
        int cnt;
        bit push, pop, thru;
        cnt = q.size();
        if (flush_i) begin
            q.delete();
        end else begin
            push = in_valid_i && cnt < DEPTH;
            pop  = out_ready_i && cnt > 0;
            thru = BYP && in_valid_i && cnt == 0 && out_ready_i;
            if (pop) void'(q.pop_front());
            if (push && !thru) q.push_back(in_data_i);
        end
        tick();
    endtask

    task automatic cyc(input logic iv, input logic [BW-1:0] d, input logic ordy, input logic fl);
        drive(iv, d, ordy, fl);
        commit();
    endtask

    initial begin
        logic [BW-1:0] rnd;
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        #1;
        check("rst_in_ready", 160'(in_ready_o), 160'(1));
        check("rst_out_valid", 160'(out_valid_o), 160'(0));
        check("rst_out_data", 160'(out_data_o), 160'(0));
        check("rst_count", 160'(count_o), 160'(0));
        check("rst_empty", 160'(empty_o), 160'(1));
        check("rst_full", 160'(full_o), 160'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, reject a fifth word, drain in order.
        for (int i = 1; i <= 4; i++) cyc(1'b1, BW'(i), 1'b0, 1'b0);
        check("fill_full", 160'(full_o), 160'(1));
        check("fill_count", 160'(count_o), 160'(4));
        drive(1'b1, BW'(5), 1'b0, 1'b0);
        check("fifth_rejected", 160'(in_ready_o), 160'(0));
        commit();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            check("drain_data", 160'(out_data_o), 160'(i));
            commit();
        end
        check("drain_empty", 160'(empty_o), 160'(1));

        // Streaming: 20 cycles push and pop together, pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, BW'(32'h10 + i), 1'b1, 1'b0);
            if (i > 0) check("stream_data", 160'(out_data_o), 160'(32'h10 + i - (BYP ? 0 : 1)));
            commit();
            check("stream_count", 160'(count_o), 160'(BYP ? 0 : 1));
        end
        while (q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush with a word offered in the same cycle.
        for (int i = 0; i < 3; i++) cyc(1'b1, BW'(32'h20 + i), 1'b0, 1'b0);
        check("preflush_count", 160'(count_o), 160'(3));
        drive(1'b1, BW'(32'hAA), 1'b0, 1'b1);
        check("flush_in_ready", 160'(in_ready_o), 160'(0));
        check("flush_out_valid", 160'(out_valid_o), 160'(0));
        commit();
        check("postflush_count", 160'(count_o), 160'(0));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            check("no_aa_valid", 160'(out_valid_o), 160'(0));
            commit();
        end
        drive(1'b1, BW'(32'h77), 1'b0, 1'b0);
        check("postflush_accept", 160'(in_ready_o), 160'(1));
        commit();
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Empty FIFO, word offered with the consumer ready.
        drive(1'b1, BW'(32'h55), 1'b1, 1'b0);
        check("byp_valid", 160'(out_valid_o), 160'(BYP ? 1 : 0));
        if (BYP) check("byp_data", 160'(out_data_o), 160'(32'h55));
        commit();
        check("byp_count", 160'(count_o), 160'(BYP ? 0 : 1));
        drive(1'b0, '0, 1'b1, 1'b0);
        check("late_valid", 160'(out_valid_o), 160'(BYP ? 0 : 1));
        if (!BYP) check("late_data", 160'(out_data_o), 160'(32'h55));
        commit();

        // Reset in the middle of operation loses pending words.
        cyc(1'b1, BW'(32'h31), 1'b0, 1'b0);
        cyc(1'b1, BW'(32'h32), 1'b0, 1'b0);
        in_valid_i = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("midrst_count", 160'(count_o), 160'(0));
        check("midrst_empty", 160'(empty_o), 160'(1));
        check("midrst_valid", 160'(out_valid_o), 160'(0));
        q.delete();
        tick();
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Random valid/ready traffic against the reference queue.
        for (int i = 0; i < 1000; i++) begin
            rnd = BW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            cyc(1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        end
        while (q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0);
        check("final_empty", 160'(empty_o), 160'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
